// File: rtl/mc_pkg.sv
`default_nettype none
// =============================================================================
// Module  : mc_pkg
// Brief   : Phase encodings and control-code constants for the multi-cycle datapath.
// Revision: 1.0 - initial release
// =============================================================================
package mc_pkg;

    localparam logic [2:0] c_fetch  = 3'd0;
    localparam logic [2:0] c_decode = 3'd1;
    localparam logic [2:0] c_exec   = 3'd2;
    localparam logic [2:0] c_mem    = 3'd3;
    localparam logic [2:0] c_wb     = 3'd4;

    localparam logic [1:0] c_wa_rt  = 2'b00;
    localparam logic [1:0] c_wa_rd  = 2'b01;
    localparam logic [1:0] c_wa_ra  = 2'b10;

    localparam logic [1:0] c_wd_alu = 2'b00;
    localparam logic [1:0] c_wd_mdr = 2'b01;
    localparam logic [1:0] c_wd_pc4 = 2'b10;

    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_or  = 3'b010;
    localparam logic [2:0] c_alu_and = 3'b011;
    localparam logic [2:0] c_alu_lui = 3'b100;

    localparam logic [1:0] c_br_pc4 = 2'b00;
    localparam logic [1:0] c_br_beq = 2'b01;
    localparam logic [1:0] c_br_jmp = 2'b10;
    localparam logic [1:0] c_br_jr  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mc_grf.sv
`default_nettype none
// =============================================================================
// Module  : mc_grf
// Brief   : NREG x DW register file, two async reads, one sync write, reg 0 = 0.
// Revision: 1.0 - initial release
// =============================================================================
module mc_grf #(
    parameter int DW   = 32,
    parameter int NREG = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    ra1_i,
    input  logic [4:0]    ra2_i,
    output logic [DW-1:0] rd1_o,
    output logic [DW-1:0] rd2_o,
    input  logic          we_i,
    input  logic [4:0]    wa_i,
    input  logic [DW-1:0] wd_i
);

    logic [DW-1:0] regs_q [NREG];

    always_comb begin
        rd1_o = '0;
        rd2_o = '0;
        if (ra1_i != 5'd0 && int'(ra1_i) < NREG) rd1_o = regs_q[ra1_i];
        if (ra2_i != 5'd0 && int'(ra2_i) < NREG) rd2_o = regs_q[ra2_i];
    end

    // Entry 0 is only ever written by reset, so it reads back as zero regardless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (we_i && wa_i != 5'd0 && int'(wa_i) < NREG) begin
            regs_q[wa_i] <= wd_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mc_datapath.sv
`default_nettype none
// =============================================================================
// Module  : mc_datapath
// Brief   : Multi-cycle MIPS-subset datapath with req/ack instruction and data memories.
// Revision: 1.0 - initial release
// =============================================================================
module mc_datapath
    import mc_pkg::*;
#(
    parameter int          DW       = 32,
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int          NREG     = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    wactr,
    input  logic [1:0]    wdctr,
    input  logic          extctr,
    input  logic          bctr,
    input  logic [2:0]    aluctr,
    input  logic          memread,
    input  logic          memwrite,
    input  logic          regwrite,
    input  logic [1:0]    brctr,
    output logic [5:0]    op,
    output logic [5:0]    func,
    output logic [2:0]    phase,
    output logic          retire,
    output logic          imem_req,
    output logic [31:0]   imem_addr,
    input  logic [31:0]   imem_rdata,
    input  logic          imem_ack,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ack
);

    logic [2:0]    state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   pc4_q, pc4_d;
    logic [31:0]   ir_q, ir_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] b_q, b_d;
    logic [DW-1:0] aluout_q, aluout_d;
    logic [DW-1:0] mdr_q, mdr_d;

    logic [DW-1:0] w_rd1, w_rd2;
    logic [15:0]   w_imm;
    logic [DW-1:0] w_ext;
    logic [DW-1:0] w_alu_b;
    logic [DW-1:0] w_alu_res;
    logic [31:0]   w_br_off;
    logic [31:0]   w_npc;
    logic [4:0]    w_wa;
    logic          w_wa_ok;
    logic [DW-1:0] w_wd;
    logic          w_wd_ok;
    logic          w_grf_we;
    logic          w_is_mem;

    assign op         = ir_q[31:26];
    assign func       = ir_q[5:0];
    assign phase      = state_q;
    assign imem_addr  = pc_q;
    assign dmem_addr  = aluout_q;
    assign dmem_wdata = b_q;
    assign w_is_mem   = memread | memwrite;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= c_fetch;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_fetch:  if (imem_ack) state_d = c_decode;
            c_decode: state_d = c_exec;
            c_exec: begin
                if (w_is_mem)      state_d = c_mem;
                else if (regwrite) state_d = c_wb;
                else               state_d = c_fetch;
            end
            c_mem:    if (dmem_ack) state_d = memwrite ? c_fetch : c_wb;
            c_wb:     state_d = c_fetch;
            default:  state_d = c_fetch;
        endcase
    end

    // Requests are gated by rst so an abandoned transfer drops without waiting for a clock.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        retire   = 1'b0;
        w_grf_we = 1'b0;
        case (state_q)
            c_fetch: imem_req = ~rst;
            c_exec:  retire   = ~rst & ~w_is_mem & ~regwrite;
            c_mem: begin
                dmem_req = ~rst;
                dmem_we  = ~rst & memwrite;
                retire   = ~rst & dmem_ack & memwrite;
            end
            c_wb: begin
                retire   = ~rst;
                w_grf_we = regwrite & w_wa_ok & w_wd_ok;
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    assign w_imm    = ir_q[15:0];
    assign w_ext    = extctr ? {{(DW-16){w_imm[15]}}, w_imm} : {{(DW-16){1'b0}}, w_imm};
    assign w_alu_b  = bctr ? w_ext : b_q;
    assign w_br_off = {{14{w_imm[15]}}, w_imm, 2'b00};

    always_comb begin
        case (aluctr)
            c_alu_add: w_alu_res = a_q + w_alu_b;
            c_alu_sub: w_alu_res = a_q - w_alu_b;
            c_alu_or:  w_alu_res = a_q | w_alu_b;
            c_alu_and: w_alu_res = a_q & w_alu_b;
            c_alu_lui: w_alu_res = DW'({w_imm, 16'h0000});
            default:   w_alu_res = '0;
        endcase
    end

    always_comb begin
        case (brctr)
            c_br_beq: w_npc = (a_q == b_q) ? pc4_q + w_br_off : pc4_q;
            c_br_jmp: w_npc = {pc4_q[31:28], ir_q[25:0], 2'b00};
            c_br_jr:  w_npc = a_q[31:0];
            default:  w_npc = pc4_q;
        endcase
    end

    always_comb begin
        w_wa_ok = 1'b1;
        case (wactr)
            c_wa_rt: w_wa = ir_q[20:16];
            c_wa_rd: w_wa = ir_q[15:11];
            c_wa_ra: w_wa = 5'd31;
            default: begin
                w_wa    = 5'd0;
                w_wa_ok = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_wd_ok = 1'b1;
        case (wdctr)
            c_wd_alu: w_wd = aluout_q;
            c_wd_mdr: w_wd = mdr_q;
            c_wd_pc4: w_wd = DW'(pc4_q);
            default: begin
                w_wd    = '0;
                w_wd_ok = 1'b0;
            end
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        pc4_d    = pc4_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        aluout_d = aluout_q;
        mdr_d    = mdr_q;
        case (state_q)
            c_fetch: begin
                if (imem_ack) begin
                    ir_d  = imem_rdata;
                    pc4_d = pc_q + 32'd4;
                end
            end
            c_decode: begin
                a_d = w_rd1;
                b_d = w_rd2;
            end
            c_exec: begin
                aluout_d = w_alu_res;
                pc_d     = w_npc;
            end
            c_mem:   if (dmem_ack && !memwrite) mdr_d = dmem_rdata;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= PC_RESET;
            pc4_q    <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            pc4_q    <= pc4_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
        end
    end

    mc_grf #(
        .DW   (DW),
        .NREG (NREG)
    ) u_grf (
        .clk   (clk),
        .rst   (rst),
        .ra1_i (ir_q[25:21]),
        .ra2_i (ir_q[20:16]),
        .rd1_o (w_rd1),
        .rd2_o (w_rd2),
        .we_i  (w_grf_we),
        .wa_i  (w_wa),
        .wd_i  (w_wd)
    );

endmodule
`default_nettype wire

// File: tb/tb_mc_datapath.sv
`default_nettype none
// =============================================================================
// Module  : tb_mc_datapath
// Brief   : Directed bench for mc_datapath with latency-programmable memory models.
// Revision: 1.0 - initial release
// =============================================================================
module tb_mc_datapath;
    import mc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  wactr, wdctr, brctr;
    logic        extctr, bctr, memread, memwrite, regwrite;
    logic [2:0]  aluctr;
    logic [5:0]  op, func;
    logic [2:0]  phase;
    logic        retire;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

    logic [31:0] imem [16];
    logic [31:0] dmem [16];
    logic [31:0] ioff;
    int          ilat = 0, dlat = 0, icnt = 0, dcnt = 0;
    logic        late_ack = 1'b0;

    int          err_cnt = 0, chk_cnt = 0;
    logic        mem_seen, mem_we_seen;
    logic [31:0] mem_addr_seen, mem_wdata_seen;

    always #5 clk = ~clk;

    mc_datapath #(.DW(32), .PC_RESET(32'h0000_3000), .NREG(32)) u_dut (
        .clk(clk), .rst(rst), .wactr(wactr), .wdctr(wdctr), .extctr(extctr),
        .bctr(bctr), .aluctr(aluctr), .memread(memread), .memwrite(memwrite),
        .regwrite(regwrite), .brctr(brctr), .op(op), .func(func), .phase(phase),
        .retire(retire), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack)
    );

    // External controller: decodes op/func into the datapath control codes.
    always_comb begin
        wactr = 2'b00; wdctr = 2'b00; extctr = 1'b0; bctr = 1'b0; aluctr = 3'b000;
        memread = 1'b0; memwrite = 1'b0; regwrite = 1'b0; brctr = 2'b00;
        case (op)
            6'h00: case (func)
                6'h21: begin wactr = 2'b01; regwrite = 1'b1; end
                6'h08: brctr = 2'b11;
                default: ;
            endcase
            6'h0D: begin bctr = 1'b1; aluctr = 3'b010; regwrite = 1'b1; end
            6'h09: begin extctr = 1'b1; bctr = 1'b1; regwrite = 1'b1; end
            6'h0F: begin bctr = 1'b1; aluctr = 3'b100; regwrite = 1'b1; end
            6'h23: begin extctr = 1'b1; bctr = 1'b1; memread = 1'b1; regwrite = 1'b1; wdctr = 2'b01; end
            6'h2B: begin extctr = 1'b1; bctr = 1'b1; memwrite = 1'b1; end
            6'h04: begin aluctr = 3'b001; brctr = 2'b01; end
            6'h02: brctr = 2'b10;
            6'h03: begin brctr = 2'b10; wactr = 2'b10; wdctr = 2'b10; regwrite = 1'b1; end
            default: ;
        endcase
    end

    assign ioff       = imem_addr - 32'h0000_3000;
    assign imem_rdata = imem[ioff[5:2]];
    assign imem_ack   = imem_req && (icnt >= ilat);
    assign dmem_rdata = dmem[dmem_addr[5:2]];
    assign dmem_ack   = (dmem_req && (dcnt >= dlat)) || late_ack;

    always @(posedge clk) begin
        if (!imem_req || imem_ack) icnt <= 0; else icnt <= icnt + 1;
        if (!dmem_req || dmem_ack) dcnt <= 0; else dcnt <= dcnt + 1;
        if (dmem_req && dmem_we && dmem_ack) dmem[dmem_addr[5:2]] <= dmem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Called mid-cycle in an instruction's first cycle; returns mid-cycle in the next one.
    task automatic run_instr(input string tag, input int exp_cyc);
        int cyc = 0;
        mem_seen = 1'b0; mem_we_seen = 1'b0; mem_addr_seen = '0; mem_wdata_seen = '0;
        while (cyc < 40) begin
            cyc++;
            if (dmem_req && !mem_seen) begin
                mem_seen = 1'b1; mem_we_seen = dmem_we;
                mem_addr_seen = dmem_addr; mem_wdata_seen = dmem_wdata;
            end
            if (retire) break;
            @(negedge clk); #1;
        end
        @(negedge clk); #1;
        check({tag, " cycles"}, cyc, exp_cyc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin imem[i] = '0; dmem[i] = '0; end
        #1 rst = 1'b1;
        #1;
        check("rst imem_req", {31'd0, imem_req}, 32'd0);
        check("rst dmem_req", {31'd0, dmem_req}, 32'd0);
        check("rst retire",   {31'd0, retire},   32'd0);

        // Program 1: ori / sw / lw / sw
        imem[0] = 32'h3401_1234;
        imem[1] = 32'hAC01_0004;
        imem[2] = 32'h8C02_0004;
        imem[3] = 32'hAC01_0008;

        ilat = 0;
        do_reset();
        check("t1 imem_req",  {31'd0, imem_req}, 32'd1);
        check("t1 imem_addr", imem_addr, 32'h0000_3000);
        check("t1 phase",     {29'd0, phase}, {29'd0, c_fetch});

        ilat = 3;
        do_reset();
        run_instr("t2 ori", 7);
        check("t2 gpr1", u_dut.u_grf.regs_q[1], 32'h0000_1234);

        ilat = 0; dlat = 2;
        run_instr("t3 sw", 6);
        check("t3 sw we",    {31'd0, mem_we_seen}, 32'd1);
        check("t3 sw addr",  mem_addr_seen, 32'd4);
        check("t3 sw wdata", mem_wdata_seen, 32'h0000_1234);
        check("t3 dmem[1]",  dmem[1], 32'h0000_1234);
        run_instr("t3 lw", 7);
        check("t3 lw req",  {31'd0, mem_seen}, 32'd1);
        check("t3 lw we",   {31'd0, mem_we_seen}, 32'd0);
        check("t3 gpr2",    u_dut.u_grf.regs_q[2], 32'h0000_1234);

        // Abandon the next store mid-MEM with reset
        dlat = 10;
        for (int i = 0; i < 20 && !dmem_req; i++) begin @(negedge clk); #1; end
        check("t6 req seen", {31'd0, dmem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6 dmem_req",  {31'd0, dmem_req}, 32'd0);
        check("t6 imem_req",  {31'd0, imem_req}, 32'd0);
        check("t6 pc",        imem_addr, 32'h0000_3000);
        check("t6 gpr1",      u_dut.u_grf.regs_q[1], 32'd0);
        check("t6 gpr2",      u_dut.u_grf.regs_q[2], 32'd0);
        check("t6 phase",     {29'd0, phase}, {29'd0, c_fetch});
        @(negedge clk); late_ack = 1'b1; #1;
        check("t6 late dmem_req", {31'd0, dmem_req}, 32'd0);
        @(negedge clk); rst = 1'b0; #1;
        check("t6 fetch addr", imem_addr, 32'h0000_3000);
        run_instr("t6 ori", 4);
        late_ack = 1'b0;
        check("t6 gpr1 after", u_dut.u_grf.regs_q[1], 32'h0000_1234);
        check("t6 dmem[2]",    dmem[2], 32'd0);

        // Program 2: control flow, link, $0 write, lui, addiu
        imem[0] = 32'h3401_1234;
        imem[1] = 32'h1021_FFFF;
        imem[2] = 32'h0C00_0C03;
        imem[3] = 32'h0021_0021;
        imem[4] = 32'h3C04_ABCD;
        imem[5] = 32'h2405_FFFE;
        imem[6] = 32'h0800_0C06;
        dlat = 0;
        do_reset();
        run_instr("t4 ori", 4);
        run_instr("t4 beq taken", 3);
        check("t4 taken addr", imem_addr, 32'h0000_3004);
        imem[1] = 32'h1023_FFFF;
        run_instr("t4 beq not", 3);
        check("t4 not-taken addr", imem_addr, 32'h0000_3008);
        run_instr("t5 jal", 4);
        check("t5 gpr31",     u_dut.u_grf.regs_q[31], 32'h0000_300C);
        check("t5 jal addr",  imem_addr, 32'h0000_300C);
        run_instr("t5 addu", 4);
        check("t5 gpr0",      u_dut.u_grf.regs_q[0], 32'd0);
        check("t5 gpr1 kept", u_dut.u_grf.regs_q[1], 32'h0000_1234);
        run_instr("lui", 4);
        check("lui gpr4",     u_dut.u_grf.regs_q[4], 32'hABCD_0000);
        run_instr("addiu", 4);
        check("addiu gpr5",   u_dut.u_grf.regs_q[5], 32'hFFFF_FFFE);
        run_instr("j", 3);
        check("j addr",       imem_addr, 32'h0000_3018);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
